// File: rtl/sel_button_counter_pkg.sv
// Shared constants and types for the button-driven selection counter.
// The LED decoder stage takes its select width from DEFAULT_SEL_W as well.
package sel_button_counter_pkg;

  parameter int unsigned DEFAULT_SEL_W           = 3;
  parameter int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    DirNone,
    DirUp,
    DirDown
  } dir_e;

  // Simultaneous presses cancel out.
  function automatic dir_e decode_dir(input logic up_press, input logic dn_press);
    unique case ({up_press, dn_press})
      2'b10:   decode_dir = DirUp;
      2'b01:   decode_dir = DirDown;
      default: decode_dir = DirNone;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, stability-count debouncer and one-cycle rising-edge press pulse
// for a single raw push-button.
module btn_debounce
  import sel_button_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync_meta_q;
  logic            sync_q;
  logic            db_q;
  logic            db_d;
  logic            db_dly_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= btn;
      sync_q      <= sync_meta_q;
    end
  end

  // Any return of sync to the accepted level restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CntLast) begin
        db_d  = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b0;
      cnt_q    <= '0;
      db_dly_q <= 1'b0;
    end else begin
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
    end
  end

  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/sel_button_counter.sv
// Up/down wrapping selection counter driven by two debounced push-buttons;
// step strobes for one cycle whenever sel takes a new value.
module sel_button_counter
  import sel_button_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SEL_W           = DEFAULT_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [SEL_W-1:0] sel,
  output logic             step
);

  logic             up_press;
  logic             dn_press;
  dir_e             dir;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             step_q;
  logic             step_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_up),
    .press(up_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_down (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_down),
    .press(dn_press)
  );

  assign dir = decode_dir(up_press, dn_press);

  // Wrap is the natural modulo-2^SEL_W overflow of the adder.
  always_comb begin
    sel_d  = sel_q;
    step_d = 1'b0;
    unique case (dir)
      DirUp: begin
        sel_d  = sel_q + SEL_W'(1);
        step_d = 1'b1;
      end
      DirDown: begin
        sel_d  = sel_q - SEL_W'(1);
        step_d = 1'b1;
      end
      default: begin
        sel_d  = sel_q;
        step_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      step_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      step_q <= step_d;
    end
  end

  assign sel  = sel_q;
  assign step = step_q;

endmodule

// File: tb/tb_sel_button_counter.sv
// Directed bench for sel_button_counter with a short debounce window.
module tb_sel_button_counter;

  localparam int unsigned Deb = 4;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] sel;
  logic       step;

  int n_checks = 0;
  int n_errors = 0;
  int n_step   = 0;

  sel_button_counter #(
    .DEBOUNCE_CYCLES(Deb),
    .SEL_W          (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .sel     (sel),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) n_step++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rise at a negedge; the next posedge is E0 and sel must move on E(Deb+2).
  task automatic press(input logic up, input logic dn, input int hold,
                       input logic [2:0] prev, input logic [2:0] exp, input string tag);
    int   n0;
    logic stable;
    n0 = n_step;
    @(negedge clk);
    btn_up   = up;
    btn_down = dn;
    stable   = 1'b1;
    for (int i = 0; i < Deb + 2; i++) begin
      @(negedge clk);
      if (sel !== prev || step !== 1'b0) stable = 1'b0;
    end
    check({tag, " early"}, 32'(stable), 32'd1);
    @(negedge clk);
    check({tag, " sel"}, 32'(sel), 32'(exp));
    check({tag, " step"}, 32'(step), 32'(exp != prev));
    repeat (hold - Deb - 3) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (Deb + 6) @(negedge clk);
    check({tag, " after"}, 32'(sel), 32'(exp));
    check({tag, " steps"}, 32'(n_step - n0), 32'(exp != prev));
  endtask

  initial begin
    logic stable;
    int   n0;
    rst      = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sel", 32'(sel), 32'd0);
    check("reset step", 32'(step), 32'd0);
    rst    = 1'b0;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sel !== 3'd0 || step !== 1'b0) stable = 1'b0;
    end
    check("idle stable", 32'(stable), 32'd1);

    press(1'b1, 1'b0, 10, 3'd0, 3'd1, "clean up");

    // Bounce 1,0,1,0 then the final rise inside press().
    n0 = n_step;
    @(negedge clk) btn_up = 1'b1;
    @(negedge clk) btn_up = 1'b0;
    @(negedge clk) btn_up = 1'b1;
    @(negedge clk) btn_up = 1'b0;
    check("bounce no step", 32'(n_step - n0), 32'd0);
    press(1'b1, 1'b0, 10, 3'd1, 3'd2, "bounce");

    press(1'b1, 1'b1, 10, 3'd2, 3'd2, "both");

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      press(1'b1, 1'b0, 8, 3'(i - 1), 3'(i), $sformatf("wrap up%0d", i));
    end
    press(1'b0, 1'b1, 8, 3'd0, 3'd7, "wrap down");

    // Asynchronous assertion mid-cycle must clear sel before any edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async rst sel", 32'(sel), 32'd0);
    check("async rst step", 32'(step), 32'd0);
    @(negedge clk) rst = 1'b0;

    press(1'b1, 1'b0, 10, 3'd0, 3'd1, "pre held");

    // btn_down held; reset at cnt=2 (after E3), released with button still down.
    n0 = n_step;
    @(negedge clk) btn_down = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 check("held rst sel", 32'(sel), 32'd0);
    @(negedge clk) rst = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < Deb + 2; i++) begin
      @(negedge clk);
      if (sel !== 3'd0 || step !== 1'b0) stable = 1'b0;
    end
    check("held early", 32'(stable), 32'd1);
    @(negedge clk);
    check("held sel", 32'(sel), 32'd7);
    check("held step", 32'(step), 32'd1);
    repeat (12) @(negedge clk);
    btn_down = 1'b0;
    repeat (Deb + 6) @(negedge clk);
    check("held after", 32'(sel), 32'd7);
    check("held steps", 32'(n_step - n0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
